// File: rtl/fifo_w_pkg.sv
// fifo_w_pkg: shared constants, hold FSM encoding and packing helpers for fifo_w
package fifo_w_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [7:0] PAD_BYTE = 8'hFF;
  localparam logic [31:0] PAD_WORD = {BYTES_PER_WORD{PAD_BYTE}};
  typedef enum logic {EMPTY, FULL} hold_state_e;
  // Pack register holds k bytes in its low lanes above PAD_BYTE fill; rotate them to the top.
  function automatic logic [31:0] left_justify(input logic [31:0] w, input logic [2:0] k);
    return (w << (8 * (BYTES_PER_WORD - int'(k)))) | (w >> (8 * int'(k)));
  endfunction
  // Upper k lanes valid.
  function automatic logic [3:0] lane_mask(input logic [2:0] k);
    logic [3:0] s;
    s = 4'b1111 << (BYTES_PER_WORD - int'(k));
    return s;
  endfunction
endpackage

// File: rtl/flex_counter.sv
// flex_counter: up counter with synchronous clear and programmable rollover value
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  // next count: clear wins over enable; wrap to 1 after reaching rollover_val
  always_comb begin
    count_d = clear ? '0 : !count_enable ? count_q : (count_q == rollover_val) ? NUM_CNT_BITS'(1) : count_q + 1'b1;
  end
  // count register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) count_q <= '0;
    else count_q <= count_d;
  end
  assign count_out = count_q;
endmodule

// File: rtl/fifo_w.sv
// fifo_w: packs bytes MSB-first into 32-bit words with a hold register and flush; HWSTRB under FIFO_W_STROBE_EN
module fifo_w
  import fifo_w_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        flush,
  output logic [31:0] HWDATA,
  output logic        word_valid,
  input  logic        word_taken,
  output logic        transfer_data_complete_w
`ifdef FIFO_W_STROBE_EN
  ,
  output logic [3:0]  HWSTRB
`endif
);
  hold_state_e state_q, state_d;
  logic [31:0] pack_q, pack_d, hold_q, hold_d, packed_w;
  logic        pulse_q, pend_q, pend_d;
  logic        accept, full_commit, flush_req, flush_commit, commit;
  logic [2:0]  count, k;
  flex_counter #(.NUM_CNT_BITS(3)) u_count (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .clear(commit),
    .count_enable(accept),
    .rollover_val(3'(BYTES_PER_WORD - 1)),
    .count_out(count)
  );
  assign byte_ready = (count != 3'(BYTES_PER_WORD - 1) || state_q == EMPTY) && !pend_q;
  // pack first, then let any flush (new or deferred) act on the packed result
  always_comb begin
    accept       = byte_valid && byte_ready;
    packed_w     = accept ? {pack_q[23:0], byte_in} : pack_q;
    k            = count + {2'b0, accept};
    full_commit  = accept && count == 3'(BYTES_PER_WORD - 1);
    flush_req    = flush || pend_q;
    flush_commit = flush_req && !full_commit && state_q == EMPTY && k != 3'd0;
    commit       = full_commit || flush_commit;
    pack_d       = commit ? PAD_WORD : packed_w;
    hold_d       = full_commit ? packed_w : flush_commit ? left_justify(packed_w, k) : hold_q;
    pend_d       = flush_req && state_q == FULL;
    state_d      = commit ? FULL : (state_q == FULL && word_taken) ? EMPTY : state_q;
  end
  // hold FSM state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= EMPTY;
    else state_q <= state_d;
  end
  // pack/hold datapath, deferred-flush flag and first-cycle pulse
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pack_q  <= PAD_WORD;
      hold_q  <= PAD_WORD;
      pend_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      pack_q  <= pack_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      pulse_q <= commit;
    end
  end
  assign HWDATA = hold_q;
  assign word_valid = state_q == FULL;
  assign transfer_data_complete_w = pulse_q;
`ifdef FIFO_W_STROBE_EN
  logic [3:0] strb_q, strb_d;
  // lane mask registered alongside the hold word
  always_comb begin
    strb_d = full_commit ? 4'b1111 : flush_commit ? lane_mask(k) : strb_q;
  end
  // strobe register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) strb_q <= 4'b0000;
    else strb_q <= strb_d;
  end
  assign HWSTRB = strb_q;
`endif
endmodule

// File: tb/tb_fifo_w.sv
// tb_fifo_w: directed and randomized checks of fifo_w against a byte-queue reference model
module tb_fifo_w;
  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0, flush = 1'b0, word_taken = 1'b0;
  logic        byte_ready, word_valid, transfer_data_complete_w;
  logic [31:0] HWDATA;
`ifdef FIFO_W_STROBE_EN
  logic [3:0]  HWSTRB;
`endif
  fifo_w dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .flush(flush),
    .HWDATA(HWDATA),
    .word_valid(word_valid),
    .word_taken(word_taken),
    .transfer_data_complete_w(transfer_data_complete_w)
`ifdef FIFO_W_STROBE_EN
    ,
    .HWSTRB(HWSTRB)
`endif
  );
  always #5 HCLK = ~HCLK;
  int n_chk = 0, n_fail = 0;
  logic [7:0]  q[$];
  logic [31:0] m_word;
  logic [3:0]  m_strb;
  bit          m_full, m_pulse, m_pend;
  function automatic bit m_ready();
    return (q.size() != 3 || !m_full) && !m_pend;
  endfunction
  task automatic reset_model();
    q.delete();
    m_word = 32'hFFFFFFFF;
    m_strb = 4'b0000;
    m_full = 0;
    m_pulse = 0;
    m_pend = 0;
  endtask
  task automatic do_commit();
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < 4; i++) begin
      w = {w[23:0], (i < q.size()) ? q[i] : 8'hFF};
      m_strb[3-i] = i < q.size();
    end
    m_word = w;
    m_full = 1;
    m_pulse = 1;
    q.delete();
  endtask
  task automatic cycle(input bit bv, input logic [7:0] b, input bit fl, input bit wt);
    bit acc, was_full, freq;
    byte_valid = bv;
    byte_in = b;
    flush = fl;
    word_taken = wt;
    acc = bv && m_ready();
    was_full = m_full;
    @(posedge HCLK);
    #1;
    m_pulse = 0;
    if (acc) q.push_back(b);
    if (q.size() == 4) do_commit();
    else begin
      freq = fl || m_pend;
      if (freq && !was_full) begin
        if (q.size() > 0) do_commit();
        m_pend = 0;
      end else if (freq) m_pend = 1;
      if (was_full && wt) m_full = 0;
    end
  endtask
  task automatic test_reset();
    HRESETn = 1'b0;
    reset_model();
    repeat (2) @(posedge HCLK);
    #1;
    n_chk++; if (HWDATA !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL reset_hwdata got=%h exp=ffffffff", HWDATA); end
    n_chk++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_word_valid got=%b exp=0", word_valid); end
    n_chk++; if (transfer_data_complete_w !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got=%b exp=0", transfer_data_complete_w); end
    n_chk++; if (byte_ready !== 1'b1) begin n_fail++; $display("FAIL reset_byte_ready got=%b exp=1", byte_ready); end
`ifdef FIFO_W_STROBE_EN
    n_chk++; if (HWSTRB !== 4'b0000) begin n_fail++; $display("FAIL reset_hwstrb got=%b exp=0000", HWSTRB); end
`endif
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask
  task automatic test_full_word();
    cycle(1, 8'h11, 0, 0);
    cycle(1, 8'h22, 0, 0);
    cycle(1, 8'h33, 0, 0);
    n_chk++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid got=%b exp=0", word_valid); end
    cycle(1, 8'h44, 0, 0);
    n_chk++; if (HWDATA !== 32'h11223344) begin n_fail++; $display("FAIL full_hwdata got=%h exp=11223344", HWDATA); end
    n_chk++; if (word_valid !== 1'b1) begin n_fail++; $display("FAIL full_word_valid got=%b exp=1", word_valid); end
    n_chk++; if (transfer_data_complete_w !== 1'b1) begin n_fail++; $display("FAIL full_pulse got=%b exp=1", transfer_data_complete_w); end
`ifdef FIFO_W_STROBE_EN
    n_chk++; if (HWSTRB !== 4'b1111) begin n_fail++; $display("FAIL full_hwstrb got=%b exp=1111", HWSTRB); end
`endif
    cycle(0, 8'h00, 0, 0);
    n_chk++; if (transfer_data_complete_w !== 1'b0) begin n_fail++; $display("FAIL full_pulse_width got=%b exp=0", transfer_data_complete_w); end
    n_chk++; if (word_valid !== 1'b1) begin n_fail++; $display("FAIL full_hold got=%b exp=1", word_valid); end
    cycle(0, 8'h00, 0, 1);
    n_chk++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL full_taken got=%b exp=0", word_valid); end
  endtask
  task automatic test_flush_partial();
    cycle(1, 8'hAA, 0, 0);
    cycle(1, 8'hBB, 0, 0);
    cycle(0, 8'h00, 1, 0);
    n_chk++; if (HWDATA !== 32'hAABBFFFF) begin n_fail++; $display("FAIL flush_hwdata got=%h exp=aabbffff", HWDATA); end
    n_chk++; if (transfer_data_complete_w !== 1'b1) begin n_fail++; $display("FAIL flush_pulse got=%b exp=1", transfer_data_complete_w); end
`ifdef FIFO_W_STROBE_EN
    n_chk++; if (HWSTRB !== 4'b1100) begin n_fail++; $display("FAIL flush_hwstrb got=%b exp=1100", HWSTRB); end
`endif
    cycle(0, 8'h00, 0, 1);
  endtask
  task automatic test_backpressure();
    for (int i = 1; i <= 7; i++) cycle(1, 8'(i), 0, 0);
    n_chk++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low got=%b exp=0", byte_ready); end
    cycle(1, 8'h08, 0, 1);
    n_chk++; if (byte_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_take got=%b exp=1", byte_ready); end
    n_chk++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got=%b exp=0", word_valid); end
    cycle(1, 8'h08, 0, 0);
    n_chk++; if (HWDATA !== 32'h05060708) begin n_fail++; $display("FAIL bp_second_word got=%h exp=05060708", HWDATA); end
    n_chk++; if (transfer_data_complete_w !== 1'b1) begin n_fail++; $display("FAIL bp_second_pulse got=%b exp=1", transfer_data_complete_w); end
  endtask
  task automatic test_pending_flush();
    cycle(1, 8'hC1, 0, 0);
    cycle(1, 8'hC2, 0, 0);
    cycle(0, 8'h00, 1, 0);
    n_chk++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL pend_ready got=%b exp=0", byte_ready); end
    n_chk++; if (HWDATA !== 32'h05060708) begin n_fail++; $display("FAIL pend_hold_kept got=%h exp=05060708", HWDATA); end
    cycle(1, 8'hC3, 0, 0);
    n_chk++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL pend_ready_still got=%b exp=0", byte_ready); end
    cycle(0, 8'h00, 0, 1);
    n_chk++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL pend_gap got=%b exp=0", word_valid); end
    cycle(0, 8'h00, 0, 0);
    n_chk++; if (HWDATA !== 32'hC1C2FFFF) begin n_fail++; $display("FAIL pend_hwdata got=%h exp=c1c2ffff", HWDATA); end
    n_chk++; if (transfer_data_complete_w !== 1'b1) begin n_fail++; $display("FAIL pend_pulse got=%b exp=1", transfer_data_complete_w); end
    n_chk++; if (byte_ready !== 1'b1) begin n_fail++; $display("FAIL pend_released got=%b exp=1", byte_ready); end
    cycle(0, 8'h00, 0, 1);
  endtask
  task automatic test_noop();
    cycle(0, 8'h00, 1, 0);
    n_chk++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL noop_flush_valid got=%b exp=0", word_valid); end
    n_chk++; if (transfer_data_complete_w !== 1'b0) begin n_fail++; $display("FAIL noop_flush_pulse got=%b exp=0", transfer_data_complete_w); end
    cycle(0, 8'h00, 0, 1);
    n_chk++; if (word_valid !== 1'b0 || byte_ready !== 1'b1) begin n_fail++; $display("FAIL noop_take got=%b%b exp=01", word_valid, byte_ready); end
    cycle(1, 8'hD1, 0, 0);
    cycle(1, 8'hD2, 0, 0);
    cycle(1, 8'hD3, 0, 0);
    cycle(1, 8'hD4, 1, 0);
    n_chk++; if (HWDATA !== 32'hD1D2D3D4) begin n_fail++; $display("FAIL flush_with_last_byte got=%h exp=d1d2d3d4", HWDATA); end
    cycle(0, 8'h00, 0, 1);
    n_chk++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL flush_with_last_noop got=%b exp=0", word_valid); end
  endtask
  task automatic test_reset_mid();
    cycle(1, 8'h5A, 0, 0);
    cycle(1, 8'h5B, 0, 0);
    byte_valid = 1'b0;
    flush = 1'b0;
    word_taken = 1'b0;
    #1;
    HRESETn = 1'b0;
    reset_model();
    #1;
    n_chk++; if (HWDATA !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rstmid_hwdata got=%h exp=ffffffff", HWDATA); end
    n_chk++; if (byte_ready !== 1'b1 || word_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl got=%b%b exp=10", byte_ready, word_valid); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 0);
    n_chk++; if (HWDATA !== 32'h01020304) begin n_fail++; $display("FAIL rstmid_next_word got=%h exp=01020304", HWDATA); end
    cycle(0, 8'h00, 0, 1);
  endtask
  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      n_chk++; if (byte_ready !== m_ready()) begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", n, byte_ready, m_ready()); end
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
      n_chk++; if (word_valid !== m_full) begin n_fail++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", n, word_valid, m_full); end
      n_chk++; if (HWDATA !== m_word) begin n_fail++; $display("FAIL rand_hwdata cyc=%0d got=%h exp=%h", n, HWDATA, m_word); end
      n_chk++; if (transfer_data_complete_w !== m_pulse) begin n_fail++; $display("FAIL rand_pulse cyc=%0d got=%b exp=%b", n, transfer_data_complete_w, m_pulse); end
`ifdef FIFO_W_STROBE_EN
      n_chk++; if (HWSTRB !== m_strb) begin n_fail++; $display("FAIL rand_hwstrb cyc=%0d got=%b exp=%b", n, HWSTRB, m_strb); end
`endif
    end
  endtask
  initial begin
    test_reset();
    test_full_word();
    test_flush_partial();
    test_backpressure();
    test_pending_flush();
    test_noop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
